// File: rtl/rgmii_rx_frame.sv
// RGMII RX byte-stream frame receiver: preamble/SFD strip, CRC-32 check, length
// qualification, optional FCS strip, packing into OUT_BYTES-wide words with status.
module rgmii_rx_frame #(
  parameter int OUT_BYTES = 4,
  parameter int STRIP_FCS = 1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic                   rxClkIn,
  input  logic                   rstIn,
  input  logic [7:0]             rxDataIn,
  input  logic                   rxDataValidIn,
  input  logic                   rxDataErrIn,
  output logic [8*OUT_BYTES-1:0] frameDataOut,
  output logic [OUT_BYTES-1:0]   frameKeepOut,
  output logic                   frameValidOut,
  output logic                   frameLastOut,
  output logic                   statusValidOut,
  output logic                   statusGoodOut,
  output logic                   statusCrcErrOut,
  output logic [15:0]            statusLenOut,
  output logic [31:0]            goodCntOut,
  output logic [31:0]            badCntOut
);

  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic                   start_frame;
  logic                   take_byte;
  logic                   eof;

  logic [31:0]            crc_q, crc_d;
  logic [15:0]            len_q, len_d;
  logic                   errf_q, errf_d;

  logic [31:0]            dly_q, dly_d;
  logic [2:0]             dly_cnt_q, dly_cnt_d;
  logic                   rel_vld;
  logic [7:0]             rel_byte;

  logic [8*OUT_BYTES-1:0] pk_data_q, pk_data_d;
  logic [CW-1:0]          pk_cnt_q, pk_cnt_d;

  logic [8*OUT_BYTES-1:0] fdat_q, fdat_d;
  logic [OUT_BYTES-1:0]   fkeep_q, fkeep_d;
  logic                   fvld_q, fvld_d;
  logic                   flast_q, flast_d;

  logic                   svld_q, svld_d;
  logic                   sgood_q, sgood_d;
  logic                   scrc_q, scrc_d;
  logic [15:0]            slen_q, slen_d;
  logic [31:0]            gcnt_q, gcnt_d;
  logic [31:0]            bcnt_q, bcnt_d;

  logic                   crc_bad;
  logic                   len_ok;
  logic                   frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [OUT_BYTES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [OUT_BYTES-1:0] m;
    for (int i = 0; i < OUT_BYTES; i++) begin
      m[i] = (CW'(i) < n);
    end
    return m;
  endfunction

  // Framing FSM: state register
  always_ff @(posedge rxClkIn) begin
    if (rstIn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM: next state and per-cycle frame events
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    eof         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rxDataValidIn) begin
          state_d = (!rxDataErrIn && rxDataIn == 8'h55) ? S_PRE : S_DROP;
        end
      end
      S_PRE: begin
        if (!rxDataValidIn) begin
          state_d = S_IDLE;
        end else if (rxDataErrIn) begin
          state_d = S_DROP;
        end else if (rxDataIn == 8'h55) begin
          state_d = S_PRE;
        end else if (rxDataIn == 8'hD5) begin
          state_d     = S_PAYLOAD;
          start_frame = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end
      S_PAYLOAD: begin
        if (rxDataValidIn) begin
          take_byte = 1'b1;
        end else begin
          eof     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!rxDataValidIn) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign crc_bad    = (crc_q != CRC_RESIDUE);
  assign len_ok     = ({16'd0, len_q} >= 32'(MIN_LEN)) && ({16'd0, len_q} <= 32'(MAX_LEN));
  assign frame_good = !crc_bad && !errf_q && len_ok;

  // Datapath: CRC/length accumulation, FCS delay line, packer, output and status
  always_comb begin
    crc_d     = crc_q;
    len_d     = len_q;
    errf_d    = errf_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    rel_vld   = 1'b0;
    rel_byte  = 8'd0;
    pk_data_d = pk_data_q;
    pk_cnt_d  = pk_cnt_q;
    fdat_d    = fdat_q;
    fkeep_d   = fkeep_q;
    fvld_d    = 1'b0;
    flast_d   = 1'b0;
    svld_d    = 1'b0;
    sgood_d   = sgood_q;
    scrc_d    = scrc_q;
    slen_d    = slen_q;
    gcnt_d    = gcnt_q;
    bcnt_d    = bcnt_q;

    if (start_frame) begin
      crc_d     = 32'hFFFFFFFF;
      len_d     = 16'd0;
      errf_d    = 1'b0;
      dly_cnt_d = 3'd0;
      pk_cnt_d  = '0;
    end

    if (take_byte) begin
      crc_d = crc_byte(crc_q, rxDataIn);
      len_d = sat_inc16(len_q);
      if (rxDataErrIn) begin
        errf_d = 1'b1;
      end
      // With stripping, a byte leaves only once four newer bytes sit behind it,
      // so the trailing FCS is never released.
      if (STRIP_FCS != 0) begin
        dly_d    = {dly_q[23:0], rxDataIn};
        rel_vld  = (dly_cnt_q == 3'd4);
        rel_byte = dly_q[31:24];
        if (dly_cnt_q != 3'd4) begin
          dly_cnt_d = dly_cnt_q + 3'd1;
        end
      end else begin
        rel_vld  = 1'b1;
        rel_byte = rxDataIn;
      end
    end

    if (rel_vld) begin
      if (pk_cnt_q == CW'(OUT_BYTES)) begin
        fvld_d         = 1'b1;
        fkeep_d        = '1;
        fdat_d         = pk_data_q;
        pk_data_d      = '0;
        pk_data_d[7:0] = rel_byte;
        pk_cnt_d       = CW'(1);
      end else begin
        pk_data_d[8*int'(pk_cnt_q) +: 8] = rel_byte;
        pk_cnt_d = pk_cnt_q + CW'(1);
      end
    end

    if (eof) begin
      if (pk_cnt_q != '0) begin
        fvld_d   = 1'b1;
        flast_d  = 1'b1;
        fkeep_d  = keep_mask(pk_cnt_q);
        fdat_d   = pk_data_q;
        pk_cnt_d = '0;
      end
      dly_cnt_d = 3'd0;
      svld_d    = 1'b1;
      sgood_d   = frame_good;
      scrc_d    = crc_bad;
      slen_d    = len_q;
      if (frame_good) begin
        gcnt_d = gcnt_q + 32'd1;
      end else begin
        bcnt_d = bcnt_q + 32'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge rxClkIn) begin
    if (rstIn) begin
      crc_q     <= '0;
      len_q     <= '0;
      errf_q    <= 1'b0;
      dly_q     <= '0;
      dly_cnt_q <= '0;
      pk_data_q <= '0;
      pk_cnt_q  <= '0;
      fdat_q    <= '0;
      fkeep_q   <= '0;
      fvld_q    <= 1'b0;
      flast_q   <= 1'b0;
      svld_q    <= 1'b0;
      sgood_q   <= 1'b0;
      scrc_q    <= 1'b0;
      slen_q    <= '0;
      gcnt_q    <= '0;
      bcnt_q    <= '0;
    end else begin
      crc_q     <= crc_d;
      len_q     <= len_d;
      errf_q    <= errf_d;
      dly_q     <= dly_d;
      dly_cnt_q <= dly_cnt_d;
      pk_data_q <= pk_data_d;
      pk_cnt_q  <= pk_cnt_d;
      fdat_q    <= fdat_d;
      fkeep_q   <= fkeep_d;
      fvld_q    <= fvld_d;
      flast_q   <= flast_d;
      svld_q    <= svld_d;
      sgood_q   <= sgood_d;
      scrc_q    <= scrc_d;
      slen_q    <= slen_d;
      gcnt_q    <= gcnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign frameDataOut    = fdat_q;
  assign frameKeepOut    = fkeep_q;
  assign frameValidOut   = fvld_q;
  assign frameLastOut    = flast_q;
  assign statusValidOut  = svld_q;
  assign statusGoodOut   = sgood_q;
  assign statusCrcErrOut = scrc_q;
  assign statusLenOut    = slen_q;
  assign goodCntOut      = gcnt_q;
  assign badCntOut       = bcnt_q;

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Directed bench for rgmii_rx_frame: one FCS-stripping and one FCS-forwarding
// instance share the same byte stream.
module tb_rgmii_rx_frame;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] rxd = 8'd0;
  logic       rxv = 1'b0;
  logic       rxe = 1'b0;

  logic [31:0] s_fd;
  logic [3:0]  s_fk;
  logic        s_fv, s_fl, s_sv, s_sg, s_sc;
  logic [15:0] s_sl;
  logic [31:0] s_gc, s_bc;

  logic [31:0] n_fd;
  logic [3:0]  n_fk;
  logic        n_fv, n_fl, n_sv, n_sg, n_sc;
  logic [15:0] n_sl;
  logic [31:0] n_gc, n_bc;

  rgmii_rx_frame #(.OUT_BYTES(4), .STRIP_FCS(1), .MIN_LEN(64), .MAX_LEN(1518)) dut_strip (
    .rxClkIn(clk), .rstIn(rst), .rxDataIn(rxd), .rxDataValidIn(rxv), .rxDataErrIn(rxe),
    .frameDataOut(s_fd), .frameKeepOut(s_fk), .frameValidOut(s_fv), .frameLastOut(s_fl),
    .statusValidOut(s_sv), .statusGoodOut(s_sg), .statusCrcErrOut(s_sc), .statusLenOut(s_sl),
    .goodCntOut(s_gc), .badCntOut(s_bc)
  );

  rgmii_rx_frame #(.OUT_BYTES(4), .STRIP_FCS(0), .MIN_LEN(64), .MAX_LEN(1518)) dut_keep (
    .rxClkIn(clk), .rstIn(rst), .rxDataIn(rxd), .rxDataValidIn(rxv), .rxDataErrIn(rxe),
    .frameDataOut(n_fd), .frameKeepOut(n_fk), .frameValidOut(n_fv), .frameLastOut(n_fl),
    .statusValidOut(n_sv), .statusGoodOut(n_sg), .statusCrcErrOut(n_sc), .statusLenOut(n_sl),
    .goodCntOut(n_gc), .badCntOut(n_bc)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] wdat  [0:511];
  logic [3:0]  wkeep [0:511];
  logic        wlast [0:511];
  int          wcnt = 0;
  int          lcnt = 0;
  logic        sgood [0:63];
  logic        scrc  [0:63];
  logic [15:0] slen  [0:63];
  int          scnt = 0;

  int          w0cnt = 0;
  logic [31:0] w0dat = 32'd0;
  logic [3:0]  w0keep = 4'd0;
  logic        w0last = 1'b0;
  logic [15:0] n_len = 16'd0;

  always @(negedge clk) begin
    if (s_fv) begin
      if (wcnt < 512) begin
        wdat[wcnt]  <= s_fd;
        wkeep[wcnt] <= s_fk;
        wlast[wcnt] <= s_fl;
      end
      wcnt <= wcnt + 1;
      if (s_fl) lcnt <= lcnt + 1;
    end
    if (s_sv) begin
      if (scnt < 64) begin
        sgood[scnt] <= s_sg;
        scrc[scnt]  <= s_sc;
        slen[scnt]  <= s_sl;
      end
      scnt <= scnt + 1;
    end
    if (n_fv) begin
      w0cnt  <= w0cnt + 1;
      w0dat  <= n_fd;
      w0keep <= n_fk;
      w0last <= n_fl;
    end
    if (n_sv) n_len <= n_sl;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    rxd = b;
    rxv = v;
    rxe = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Preamble, SFD, payload bytes 0,1,2.., FCS (last byte optionally corrupted), one gap cycle.
  task automatic send_frame(input int n, input logic [7:0] fcs_xor, input int err_at,
                            output logic [31:0] fcs);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(8'(i), 1'b1, (i == err_at));
      c = crc_step(c, 8'(i));
    end
    fcs = ~c;
    drive(fcs[7:0], 1'b1, 1'b0);
    drive(fcs[15:8], 1'b1, 1'b0);
    drive(fcs[23:16], 1'b1, 1'b0);
    drive(fcs[31:24] ^ fcs_xor, 1'b1, 1'b0);
    drive(8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int wb, sb, lb, nb;
    logic [31:0] fcs;

    rst = 1'b1;
    idle(3);
    check("rst_valid", 64'(s_fv), 64'd0);
    check("rst_data", 64'(s_fd), 64'd0);
    check("rst_status", 64'({s_sv, s_sg, s_sc, s_sl}), 64'd0);
    check("rst_counters", 64'({s_gc, s_bc}), 64'd0);
    rst = 1'b0;
    idle(2);

    // 60-byte payload, good FCS
    wb = wcnt; sb = scnt; nb = w0cnt;
    send_frame(60, 8'h00, -1, fcs);
    idle(3);
    check("t1_words", 64'(wcnt - wb), 64'd15);
    check("t1_first", 64'(wdat[wb]), 64'h03020100);
    check("t1_mid_last", 64'(wlast[wb+13]), 64'd0);
    check("t1_final_data", 64'(wdat[wb+14]), 64'h3B3A3938);
    check("t1_final_keep", 64'(wkeep[wb+14]), 64'hF);
    check("t1_final_last", 64'(wlast[wb+14]), 64'd1);
    check("t1_status_cnt", 64'(scnt - sb), 64'd1);
    check("t1_good", 64'(sgood[sb]), 64'd1);
    check("t1_crcerr", 64'(scrc[sb]), 64'd0);
    check("t1_len", 64'(slen[sb]), 64'd64);
    check("t1_goodcnt", 64'(s_gc), 64'd1);
    check("t1_badcnt", 64'(s_bc), 64'd0);
    check("t1_nostrip_words", 64'(w0cnt - nb), 64'd16);
    check("t1_nostrip_fcs", 64'(w0dat), 64'(fcs));
    check("t1_nostrip_keep", 64'(w0keep), 64'hF);
    check("t1_nostrip_last", 64'(w0last), 64'd1);
    check("t1_nostrip_len", 64'(n_len), 64'd64);

    // 61-byte payload: one-byte final word
    wb = wcnt; sb = scnt;
    send_frame(61, 8'h00, -1, fcs);
    idle(3);
    check("t2_words", 64'(wcnt - wb), 64'd16);
    check("t2_final_byte", 64'(wdat[wb+15][7:0]), 64'h3C);
    check("t2_final_keep", 64'(wkeep[wb+15]), 64'h1);
    check("t2_final_last", 64'(wlast[wb+15]), 64'd1);
    check("t2_len", 64'(slen[sb]), 64'd65);
    check("t2_good", 64'(sgood[sb]), 64'd1);
    check("t2_goodcnt", 64'(s_gc), 64'd2);

    // Corrupted final FCS byte
    wb = wcnt; sb = scnt;
    send_frame(60, 8'h01, -1, fcs);
    idle(3);
    check("t3_words", 64'(wcnt - wb), 64'd15);
    check("t3_first", 64'(wdat[wb]), 64'h03020100);
    check("t3_crcerr", 64'(scrc[sb]), 64'd1);
    check("t3_good", 64'(sgood[sb]), 64'd0);
    check("t3_badcnt", 64'(s_bc), 64'd1);

    // Runt: 20 payload bytes, valid FCS
    wb = wcnt; sb = scnt;
    send_frame(20, 8'h00, -1, fcs);
    idle(3);
    check("t4_words", 64'(wcnt - wb), 64'd5);
    check("t4_len", 64'(slen[sb]), 64'd24);
    check("t4_crcerr", 64'(scrc[sb]), 64'd0);
    check("t4_good", 64'(sgood[sb]), 64'd0);
    check("t4_badcnt", 64'(s_bc), 64'd2);

    // PHY error on payload byte 10
    sb = scnt;
    send_frame(60, 8'h00, 10, fcs);
    idle(3);
    check("t5_crcerr", 64'(scrc[sb]), 64'd0);
    check("t5_good", 64'(sgood[sb]), 64'd0);
    check("t5_badcnt", 64'(s_bc), 64'd3);
    check("t5_goodcnt", 64'(s_gc), 64'd2);

    // Broken preamble is dropped silently
    wb = wcnt; sb = scnt;
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hAA, 1'b1, 1'b0);
    repeat (10) drive(8'h11, 1'b1, 1'b0);
    idle(3);
    check("t6_no_words", 64'(wcnt - wb), 64'd0);
    check("t6_no_status", 64'(scnt - sb), 64'd0);
    check("t6_counters", 64'({s_gc, s_bc}), {32'd2, 32'd3});

    // Back-to-back frames with a single gap cycle
    wb = wcnt; sb = scnt; lb = lcnt;
    send_frame(60, 8'h00, -1, fcs);
    send_frame(60, 8'h00, -1, fcs);
    idle(3);
    check("t7_status_cnt", 64'(scnt - sb), 64'd2);
    check("t7_good_a", 64'(sgood[sb]), 64'd1);
    check("t7_good_b", 64'(sgood[sb+1]), 64'd1);
    check("t7_words", 64'(wcnt - wb), 64'd30);
    check("t7_lasts", 64'(lcnt - lb), 64'd2);
    check("t7_goodcnt", 64'(s_gc), 64'd4);

    // Reset at payload byte 30 aborts the frame
    sb = scnt; lb = lcnt;
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive(8'(i), 1'b1, 1'b0);
    rst = 1'b1;
    drive(8'd30, 1'b1, 1'b0);
    rst = 1'b0;
    idle(2);
    check("t8_abort_status", 64'(scnt - sb), 64'd0);
    check("t8_abort_last", 64'(lcnt - lb), 64'd0);
    check("t8_abort_valid", 64'(s_fv), 64'd0);
    check("t8_abort_counters", 64'({s_gc, s_bc}), 64'd0);
    wb = wcnt; sb = scnt;
    send_frame(60, 8'h00, -1, fcs);
    idle(3);
    check("t8_words", 64'(wcnt - wb), 64'd15);
    check("t8_first", 64'(wdat[wb]), 64'h03020100);
    check("t8_good", 64'(sgood[sb]), 64'd1);
    check("t8_goodcnt", 64'(s_gc), 64'd1);
    check("t8_badcnt", 64'(s_bc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
